divisor_secuencial: RTL
=======================

Name: divisor_secuencial

Overview:
- Division engine that consumes the operands produced by the operand-entry block: the 4-bit dividend (numerador) and divisor chosen with up/down/ok.
- Computes the unsigned integer quotient and remainder with a restoring shift-subtract algorithm, one quotient bit per clock.
- Simple start/done handshake on the entry side; registered cociente/resto drive the display path.

Parameters:
- WIDTH, 4, operand/result width in bits (supported range 2..16).

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately
- start  input  1  request a division; sampled only in IDLE
- dividendo  input  WIDTH  dividend; captured on the edge that accepts start
- divisor  input  WIDTH  divisor; captured on the edge that accepts start
- busy  output  1  high while an accepted division is in progress
- done  output  1  single-cycle pulse: results valid and just updated
- cociente  output  WIDTH  quotient, held until the next completion
- resto  output  WIDTH  remainder, held until the next completion
- div_cero  output  1  high with the last result if its divisor was 0; held like the results

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - busy, done, div_cero = 0; cociente, resto = 0.
  - Internal remainder, quotient and counter registers = 0.
  - Reset asserted mid-calculation aborts the division; no done pulse is produced.
- States: IDLE, CALC.
- IDLE, start=1, divisor!=0, at edge k:
  - Capture Q=dividendo, D=divisor; clear partial remainder R (WIDTH+1 bits); set counter=WIDTH.
  - Go to CALC; busy=1 from edge k.
- IDLE, start=1, divisor==0, at edge k (no CALC):
  - cociente=all ones, resto=dividendo, div_cero=1, done=1 for one cycle.
  - Stay in IDLE; busy stays 0.
- CALC, each edge, one iteration:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]}; Q shifts left.
  - If T>=D: R=T-D and Q LSB=1; else R=T and Q LSB=0.
  - counter decrements.
- CALC, the edge where counter goes 1->0 (edge k+WIDTH):
  - cociente=final Q, resto=R[WIDTH-1:0], div_cero=0, done=1 for one cycle.
  - busy=0; state=IDLE.
- Latency: done visible the cycle after edge k+WIDTH (WIDTH clocks after acceptance); 1 clock for divide-by-zero.
- start while busy: ignored, with no queuing; operand changes during CALC have no effect.
- start high in the same cycle done is high: accepted, since state is already IDLE. Back-to-back divisions need no idle gap.
- start held high continuously: a new division is accepted each time IDLE is reached.
- done is never high for two consecutive cycles except back-to-back divide-by-zero requests.
- Result outputs change only on completion or reset.
- Arithmetic is unsigned; the R compare/subtract uses WIDTH+1 bits so no overflow occurs for any operand pair.
- Invariant: dividendo = cociente*divisor + resto, with resto < divisor, whenever div_cero=0.

Test Plan:
- Reset, then start with dividendo=13, divisor=4 → busy 4 cycles, done pulse once, cociente=3, resto=1, div_cero=0.
- 15/1 → cociente=15, resto=0. 3/9 → cociente=0, resto=3. 15/15 → cociente=1, resto=0.
- 7/0 → done the cycle after acceptance, busy never high, cociente=15, resto=7, div_cero=1. A following 9/2 → cociente=4, resto=1, div_cero=0.
- Start 13/4, then pulse start with 8/2 and change operands while busy → ignored; result stays 3 r1; exactly one done.
- Start 13/4, assert reset asynchronously (mid-cycle) after 2 CALC cycles → outputs 0 immediately, no done. After release, 10/3 → cociente=3, resto=1.
- Hold start high with fixed 14/5 → done every 5th cycle (accept edge + 4 CALC edges, re-accepted on the done cycle), each time cociente=2, resto=4. Exhaustive sweep of all 256 operand pairs checked against a reference model, including the divide-by-zero rule.

Source files
------------

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: unsigned restoring shift-subtract divider, one quotient bit per clock.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high; clears all state and outputs
//   start      request a division; only honoured in IDLE
//   dividendo  dividend, captured on the accepting edge
//   divisor    divisor, captured on the accepting edge
//   busy       high while an accepted division is iterating
//   done       one-cycle pulse when cociente/resto/div_cero have just been updated
//   cociente   quotient, held until the next completion
//   resto      remainder, held until the next completion
//   div_cero   last result came from a zero divisor (cociente=all ones, resto=dividendo)
module divisor_secuencial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cociente,
    output logic [WIDTH-1:0] resto,
    output logic             div_cero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StCalc} state_t;

    state_t state_q, state_d;

    logic [WIDTH:0]   r_q, r_d;     // partial remainder, one bit wider so T-D never overflows
    logic [WIDTH-1:0] q_q, q_d;     // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             done_d, div_cero_d;
    logic [WIDTH-1:0] cociente_d, resto_d;

    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             last_iter;
    logic             zero_div;

    assign trial     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign fits      = trial >= {1'b0, d_q};
    assign r_next    = fits ? (trial - {1'b0, d_q}) : trial;
    assign q_next    = {q_q[WIDTH-2:0], fits};
    assign last_iter = (cnt_q == CW'(1));
    assign zero_div  = (divisor == '0);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start && !zero_div) state_d = StCalc;
            StCalc: if (last_iter) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == StCalc);
    end

    // Datapath next values
    always_comb begin
        r_d        = r_q;
        q_d        = q_q;
        d_d        = d_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        div_cero_d = div_cero;
        cociente_d = cociente;
        resto_d    = resto;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (zero_div) begin
                        // Completes immediately without entering CALC
                        cociente_d = '1;
                        resto_d    = dividendo;
                        div_cero_d = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        q_d   = dividendo;
                        d_d   = divisor;
                        r_d   = '0;
                        cnt_d = CW'(WIDTH);
                    end
                end
            end
            StCalc: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q - CW'(1);
                if (last_iter) begin
                    cociente_d = q_next;
                    resto_d    = r_next[WIDTH-1:0];
                    div_cero_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            done     <= 1'b0;
            div_cero <= 1'b0;
            cociente <= '0;
            resto    <= '0;
        end else begin
            r_q      <= r_d;
            q_q      <= q_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            done     <= done_d;
            div_cero <= div_cero_d;
            cociente <= cociente_d;
            resto    <= resto_d;
        end
    end

endmodule
